// File: rtl/serial_to_parallel_deser.sv
// serial_to_parallel_deser
// Collects a valid-qualified serial bit stream into WIDTH-bit words for the
// downstream priority encoder. A completed word appears one cycle after its
// last bit together with a one-cycle valid pulse. A partial word that sits
// idle for TIMEOUT cycles is dropped and flagged with a one-cycle pulse.
//
// Ports:
//   clk_i            - clock, all logic on rising edge
//   srst_i           - synchronous reset, active-low
//   data_i           - serial data bit
//   data_val_i       - data_i valid this cycle (always accepted)
//   deser_data_o     - last completed word
//   deser_data_val_o - one-cycle pulse, deser_data_o updated
//   timeout_err_o    - one-cycle pulse, partial word discarded
//   busy_o           - partial word in progress
//
// state   | meaning
// IDLE    | bit count is 0, no partial word held
// COLLECT | 1..WIDTH-1 bits of the current word received
module serial_to_parallel_deser #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic             deser_data_val_o,
  output logic             timeout_err_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  // Idle counter only needs to reach TIMEOUT-1; the next idle cycle fires.
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_base, shift_ins;
  logic             done_q, done_d;
  logic             err_d;

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q          <= IDLE;
      bit_cnt_q        <= '0;
      idle_cnt_q       <= '0;
      shift_q          <= '0;
      done_q           <= 1'b0;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
      timeout_err_o    <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      idle_cnt_q       <= idle_cnt_d;
      shift_q          <= shift_d;
      done_q           <= done_d;
      // shift_q holds the finished word for exactly the cycle done_q is set.
      if (done_q) deser_data_o <= shift_q;
      deser_data_val_o <= done_q;
      timeout_err_o    <= err_d;
      busy_o           <= (bit_cnt_d != '0);
    end
  end

  always_comb begin
    // A finished word is still parked in shift_q for one cycle; a new word
    // starting right behind it must begin from a clean register.
    shift_base = done_q ? '0 : shift_q;
    shift_ins  = shift_base;
    if (MSB_FIRST) shift_ins = {shift_base[WIDTH-2:0], data_i};
    else           shift_ins[bit_cnt_q] = data_i;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    shift_d    = shift_base;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (data_val_i) begin
          shift_d   = shift_ins;
          bit_cnt_d = CW'(1);
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (data_val_i) begin
          shift_d    = shift_ins;
          idle_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (TIMEOUT > 0) begin
          if (idle_cnt_q == IDLE_LAST) begin
            bit_cnt_d  = '0;
            idle_cnt_d = '0;
            shift_d    = '0;
            err_d      = 1'b1;
            state_d    = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_to_parallel_deser.sv
// Directed bench for serial_to_parallel_deser. Three instances:
//   u0: MSB first, TIMEOUT=8   u1: LSB first, TIMEOUT=8   u2: MSB first, TIMEOUT=0
module tb_serial_to_parallel_deser;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        din   [3];
  logic        dval  [3];
  logic [15:0] q     [3];
  logic        qval  [3];
  logic        terr  [3];
  logic        busy  [3];

  int checks = 0;
  int errors = 0;

  int          npulse [3];
  int          nerr   [3];
  int          nboth  [3];
  logic [15:0] last_w [3];
  logic [15:0] words0 [$];

  always #5 clk = ~clk;

  serial_to_parallel_deser #(.WIDTH(16), .MSB_FIRST(1'b1), .TIMEOUT(8)) u0 (
    .clk_i(clk), .srst_i(rst_n[0]), .data_i(din[0]), .data_val_i(dval[0]),
    .deser_data_o(q[0]), .deser_data_val_o(qval[0]), .timeout_err_o(terr[0]), .busy_o(busy[0]));

  serial_to_parallel_deser #(.WIDTH(16), .MSB_FIRST(1'b0), .TIMEOUT(8)) u1 (
    .clk_i(clk), .srst_i(rst_n[1]), .data_i(din[1]), .data_val_i(dval[1]),
    .deser_data_o(q[1]), .deser_data_val_o(qval[1]), .timeout_err_o(terr[1]), .busy_o(busy[1]));

  serial_to_parallel_deser #(.WIDTH(16), .MSB_FIRST(1'b1), .TIMEOUT(0)) u2 (
    .clk_i(clk), .srst_i(rst_n[2]), .data_i(din[2]), .data_val_i(dval[2]),
    .deser_data_o(q[2]), .deser_data_val_o(qval[2]), .timeout_err_o(terr[2]), .busy_o(busy[2]));

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (qval[k]) begin
        npulse[k]++;
        last_w[k] = q[k];
        if (k == 0) words0.push_back(q[k]);
      end
      if (terr[k]) nerr[k]++;
      if (qval[k] && terr[k]) nboth[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic b);
    dval[k] = v;
    din[k]  = b;
    tick();
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) drive(k, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] w;
    int busy_low;
    int p0, e0;

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; din[k] = 1'b1; dval[k] = 1'b1;
      npulse[k] = 0; nerr[k] = 0; nboth[k] = 0; last_w[k] = '0;
    end
    // reset held with valid asserted: reset must win
    tick(); tick();
    chk("rst_q",    32'(q[0]),    32'h0);
    chk("rst_val",  32'(qval[0]), 32'h0);
    chk("rst_err",  32'(terr[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      dval[k] = 1'b0; din[k] = 1'b0; rst_n[k] = 1'b1;
    end
    tick();

    // back-to-back words, MSB first
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) drive(0, 1'b1, w[15-i]);
    chk("b2b_no_early_val", 32'(qval[0]), 32'h0);
    w = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, w[15-i]);
      if (i == 0) begin
        chk("b2b_val1_latency", 32'(qval[0]), 32'h1);
        chk("b2b_word1",        32'(q[0]),    32'hA5C3);
      end
      if (i == 1) chk("b2b_val1_one_cycle", 32'(qval[0]), 32'h0);
    end
    idle(0, 1);
    chk("b2b_val2", 32'(qval[0]), 32'h1);
    chk("b2b_word2_out", 32'(q[0]), 32'h0001);
    idle(0, 3);
    chk("b2b_hold_word", 32'(q[0]), 32'h0001);
    chk("b2b_pulses", 32'(words0.size()), 32'd2);
    if (words0.size() == 2) begin
      chk("b2b_q0", 32'(words0[0]), 32'hA5C3);
      chk("b2b_q1", 32'(words0[1]), 32'h0001);
    end

    // LSB first with 3-cycle gaps between bits
    w = 16'h8001;
    busy_low = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1'b1, w[i]);
      if (i < 15) begin
        if (!busy[1]) busy_low++;
        for (int g = 0; g < 3; g++) begin
          drive(1, 1'b0, 1'b0);
          if (!busy[1]) busy_low++;
        end
      end
    end
    chk("lsb_busy_after_last", 32'(busy[1]), 32'h0);
    idle(1, 2);
    chk("lsb_busy_during_word", 32'(busy_low), 32'd0);
    chk("lsb_pulses", 32'(npulse[1]), 32'd1);
    chk("lsb_word",   32'(last_w[1]), 32'h8001);
    chk("lsb_no_err", 32'(nerr[1]),   32'd0);

    // timeout after 5 bits and 8 idle cycles
    p0 = npulse[0];
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 1'b1);
    idle(0, 7);
    chk("to_no_err_at_7",  32'(terr[0]), 32'h0);
    chk("to_busy_at_7",    32'(busy[0]), 32'h1);
    idle(0, 1);
    chk("to_err_at_8",     32'(terr[0]), 32'h1);
    chk("to_busy_cleared", 32'(busy[0]), 32'h0);
    idle(0, 1);
    chk("to_err_one_cycle", 32'(terr[0]), 32'h0);
    w = 16'h1234;
    for (int i = 0; i < 16; i++) drive(0, 1'b1, w[15-i]);
    idle(0, 2);
    chk("to_after_pulses", 32'(npulse[0] - p0), 32'd1);
    chk("to_after_word",   32'(last_w[0]),      32'h1234);
    chk("to_err_count",    32'(nerr[0]),        32'd1);

    // timeout edge: valid bit on the 8th idle cycle rescues the word
    e0 = nerr[0];
    p0 = npulse[0];
    w = 16'hBEEF;
    for (int i = 0; i < 5; i++) drive(0, 1'b1, w[15-i]);
    idle(0, 7);
    for (int i = 5; i < 16; i++) drive(0, 1'b1, w[15-i]);
    idle(0, 2);
    chk("edge_no_err", 32'(nerr[0] - e0),   32'd0);
    chk("edge_pulses", 32'(npulse[0] - p0), 32'd1);
    chk("edge_word",   32'(last_w[0]),      32'hBEEF);

    // reset mid-word
    e0 = nerr[0];
    p0 = npulse[0];
    for (int i = 0; i < 10; i++) drive(0, 1'b1, 1'b0);
    rst_n[0] = 1'b0;
    drive(0, 1'b0, 1'b0);
    rst_n[0] = 1'b1;
    chk("mrst_q",    32'(q[0]),    32'h0);
    chk("mrst_busy", 32'(busy[0]), 32'h0);
    chk("mrst_val",  32'(qval[0]), 32'h0);
    chk("mrst_err",  32'(terr[0]), 32'h0);
    for (int i = 0; i < 16; i++) drive(0, 1'b1, 1'b1);
    idle(0, 12);
    chk("mrst_pulses", 32'(npulse[0] - p0), 32'd1);
    chk("mrst_word",   32'(last_w[0]),      32'hFFFF);
    chk("mrst_no_err", 32'(nerr[0] - e0),   32'd0);

    // TIMEOUT=0: partial word waits indefinitely
    w = 16'hC0DE;
    for (int i = 0; i < 3; i++) drive(2, 1'b1, w[15-i]);
    idle(2, 1000);
    chk("nto_busy_waiting", 32'(busy[2]), 32'h1);
    for (int i = 3; i < 16; i++) drive(2, 1'b1, w[15-i]);
    idle(2, 2);
    chk("nto_pulses", 32'(npulse[2]), 32'd1);
    chk("nto_word",   32'(last_w[2]), 32'hC0DE);
    chk("nto_no_err", 32'(nerr[2]),   32'd0);

    for (int k = 0; k < 3; k++) chk($sformatf("val_err_overlap_u%0d", k), 32'(nboth[k]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
